// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl : instruction-fetch sequencer.
// Writes the external (non-reset) PC register, issues one valid/ready fetch to
// instruction memory at a time, buffers the returned instruction for decode and
// advances the PC by 4 or to a redirect target.
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_kill_cnt.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int                SIZE         = 64,
   parameter int                INSTR_W      = 32,
   parameter logic [SIZE-1:0]   RESET_VECTOR = 64'h0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SIZE-1:0]      pc_cur,
   output logic                 pc_en,
   output logic [SIZE-1:0]      pc_next,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [SIZE-1:0]      imem_req_addr,
   input  logic                 imem_rsp_valid,
   input  logic [INSTR_W-1:0]   imem_rsp_data,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [INSTR_W-1:0]   instr_data,
   output logic [SIZE-1:0]      instr_pc,
   input  logic                 redirect_valid,
   input  logic [SIZE-1:0]      redirect_target
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          perf_fetch_cnt,
   output logic [31:0]          perf_kill_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [SIZE-1:0] PC_STEP = SIZE'(3'd4);
   localparam logic [SIZE-1:0] PC_ZERO = {SIZE{1'b0}};

   state_t            state_r;
   state_t            state_nxt_s;
   logic              kill_r;
   logic              kill_nxt_s;
   logic [SIZE-1:0]   req_pc_r;

   logic              pc_en_s;
   logic [SIZE-1:0]   pc_next_s;
   logic              req_valid_s;
   logic [SIZE-1:0]   req_addr_s;
   logic              capture_req_s;   // request accepted: remember its PC
   logic              load_instr_s;    // response kept: fill instruction buffer
   logic              clr_instr_s;     // buffer consumed or flushed

   // State and kill flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BOOT;
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         kill_r  <= kill_nxt_s;
      end
   end

   // Next-state decode and combinational PC / request controls
   always_comb begin
      state_nxt_s   = state_r;
      kill_nxt_s    = kill_r;
      pc_en_s       = 1'b0;
      pc_next_s     = PC_ZERO;
      req_valid_s   = 1'b0;
      req_addr_s    = PC_ZERO;
      capture_req_s = 1'b0;
      load_instr_s  = 1'b0;
      clr_instr_s   = 1'b0;
      case (state_r)
         ST_BOOT: begin
            // The PC register has no reset, so seed it before the first fetch.
            pc_en_s     = 1'b1;
            pc_next_s   = RESET_VECTOR;
            state_nxt_s = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid) begin
               // Request suppressed; fetch restarts from the new PC next cycle.
               pc_en_s   = 1'b1;
               pc_next_s = redirect_target;
            end else begin
               req_valid_s = 1'b1;
               req_addr_s  = pc_cur;
               if (imem_req_ready) begin
                  capture_req_s = 1'b1;
                  state_nxt_s   = ST_WAIT;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid && redirect_valid) begin
               pc_en_s     = 1'b1;
               pc_next_s   = redirect_target;
               kill_nxt_s  = 1'b0;
               state_nxt_s = ST_REQ;
            end else if (imem_rsp_valid) begin
               if (kill_r) begin
                  kill_nxt_s  = 1'b0;
                  state_nxt_s = ST_REQ;
               end else begin
                  load_instr_s = 1'b1;
                  state_nxt_s  = ST_HOLD;
               end
            end else if (redirect_valid) begin
               // Response still in flight: mark it stale, keep waiting for it.
               pc_en_s    = 1'b1;
               pc_next_s  = redirect_target;
               kill_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_en_s     = 1'b1;
               pc_next_s   = redirect_target;
               clr_instr_s = 1'b1;
               state_nxt_s = ST_REQ;
            end else if (instr_ready) begin
               pc_en_s     = 1'b1;
               pc_next_s   = instr_pc + PC_STEP;
               clr_instr_s = 1'b1;
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_BOOT;
            kill_nxt_s  = 1'b0;
         end
      endcase
   end

   // Request PC and instruction buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pc_r    <= PC_ZERO;
         instr_valid <= 1'b0;
         instr_data  <= {INSTR_W{1'b0}};
         instr_pc    <= PC_ZERO;
      end else begin
         if (capture_req_s) begin
            req_pc_r <= pc_cur;
         end
         if (load_instr_s) begin
            instr_valid <= 1'b1;
            instr_data  <= imem_rsp_data;
            instr_pc    <= req_pc_r;
         end else if (clr_instr_s) begin
            instr_valid <= 1'b0;
         end
      end
   end

   // Reset holds BOOT asynchronously; keep its PC write and any request off
   // until rst_n is released.
   assign pc_en          = pc_en_s && rst_n;
   assign pc_next        = pc_en ? pc_next_s : PC_ZERO;
   assign imem_req_valid = req_valid_s && rst_n;
   assign imem_req_addr  = imem_req_valid ? req_addr_s : PC_ZERO;

`ifdef FETCH_PERF_EN
   logic handshake_s;
   logic discard_s;

   assign handshake_s = (state_r == ST_HOLD) && instr_ready;
   assign discard_s   = (state_r == ST_WAIT) && imem_rsp_valid && (kill_r || redirect_valid);

   // Performance counters, free-running with natural 32-bit wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= 32'd0;
         perf_kill_cnt  <= 32'd0;
      end else begin
         if (handshake_s) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (discard_s) begin
            perf_kill_cnt <= perf_kill_cnt + 32'd1;
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer: the writer side of the 64-bit program-counter register.
- Reads the current PC and issues a valid/ready request to instruction memory.
- Buffers the returned instruction for decode, then writes the next index (PC+4 or redirect target) back into the PC register via its enable/data inputs.
- Owns PC initialisation, since the PC register itself has no reset.

Parameters:
- SIZE, 64, PC/address width in bits.
- INSTR_W, 32, instruction width in bits.
- RESET_VECTOR, 64'h0, first PC loaded after reset.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- pc_cur  in  SIZE  current value held in PC register.
- pc_en  out  1  write enable to PC register.
- pc_next  out  SIZE  value written to PC register when pc_en=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  SIZE  fetch address.
- imem_rsp_valid  in  1  response strobe (one cycle per accepted request).
- imem_rsp_data  in  INSTR_W  fetched instruction.
- instr_valid  out  1  instruction buffer holds a valid instruction.
- instr_ready  in  1  decode accepts instruction.
- instr_data  out  INSTR_W  buffered instruction.
- instr_pc  out  SIZE  PC of buffered instruction.
- redirect_valid  in  1  branch/jump redirect strobe.
- redirect_target  in  SIZE  redirect PC.

Behaviour:
- FSM states: BOOT, REQ, WAIT, HOLD. Plus a kill flag and registers req_pc, instr_data, instr_pc.
- Reset (async, rst_n=0):
  - state=BOOT, kill=0.
  - instr_valid=0, instr_data=0, instr_pc=0, req_pc=0.
  - pc_en=0 and imem_req_valid=0 while in reset.
- BOOT:
  - pc_en=1, pc_next=RESET_VECTOR for exactly one cycle.
  - Next state is REQ. Redirect is ignored in BOOT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_cur.
  - On valid&ready: req_pc<=pc_cur, then go to WAIT.
  - If redirect_valid: imem_req_valid is forced 0; pc_en=1, pc_next=redirect_target; stay in REQ. The new pc_cur is visible the next cycle.
- WAIT:
  - No request is issued.
  - On imem_rsp_valid with kill=0: instr_data<=imem_rsp_data, instr_pc<=req_pc, instr_valid<=1, then go to HOLD.
  - On imem_rsp_valid with kill=1: the response is discarded, kill<=0, then go to REQ.
  - On redirect_valid (no response that cycle): pc_en=1, pc_next=redirect_target, kill<=1, stay in WAIT.
  - Redirect coinciding with a response: the response is discarded, the PC is written with the target, then go to REQ.
- HOLD:
  - instr_valid=1.
  - On instr_ready without redirect: pc_en=1, pc_next=instr_pc+4; instr_valid<=0; go to REQ.
  - On redirect_valid: pc_en=1, pc_next=redirect_target; instr_valid<=0; go to REQ. This applies whether or not instr_ready is high; the handshake counts as complete if instr_ready=1.
- Arithmetic: instr_pc+4 is modulo 2^SIZE, so it wraps from all-ones-minus-3 to 0.
- pc_en is asserted only in the cases listed above; pc_next=0 when pc_en=0.
- imem_rsp_valid outside WAIT is ignored.
- Throughput: at most one instruction per 3 cycles plus memory latency. No speculative prefetch.
- Reset mid-operation: the outstanding request is abandoned and the FSM restarts from BOOT. Memory is reset on the same rst_n.

Optional Feature:
- FETCH_PERF_EN:
  - Defined: adds output ports perf_fetch_cnt [31:0] and perf_kill_cnt [31:0], both reset to 0.
  - perf_fetch_cnt increments on each decode handshake in HOLD.
  - perf_kill_cnt increments on each discarded response.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_VECTOR=64'h1000 -> pc_en=1/pc_next=64'h1000 one cycle later; next cycle imem_req_addr=64'h1000, imem_req_valid=1.
- Memory ready=1, response 2 cycles later data=32'hDEADBEEF, instr_ready=1 -> instr_valid with instr_pc=64'h1000 and instr_data=32'hDEADBEEF; then pc_en=1, pc_next=64'h1004.
- instr_ready held 0 for 5 cycles in HOLD -> instr_valid stays 1, pc_en stays 0, no new request.
- redirect_valid, target=64'h2000, in WAIT -> pc_next=64'h2000; following response discarded; next request addr=64'h2000 (perf_kill_cnt=1 with FETCH_PERF_EN).
- instr_pc=64'hFFFF_FFFF_FFFF_FFFC accepted -> pc_next=64'h0.
- rst_n asserted while in WAIT -> outputs zero immediately (async); after release the BOOT sequence repeats with RESET_VECTOR.
